// File: rtl/dmem_arbiter.sv
// Data-RAM port-1 arbiter between CPU and DMA with bursts and zero-latency grant.
// Optional starvation guard: define DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_wen,
  output logic        cpu_stall,
  output logic        cpu_rvld,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  input  logic        dma_wen,
  input  logic [3:0]  dma_len,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic        dma_rvld,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wen,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    DMA
  } state_e;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  if (BURST_MAX < 1 || BURST_MAX > 15 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
    $error("dmem_arbiter: parameter out of range");
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  len_clamp, beat_cnt;
  logic        own_cpu, own_dma, done;
  logic        done_q, forced;
  logic        rd_cpu_q, rd_dma_q;
  logic [15:0] cpu_hold_q, dma_hold_q;

  always_comb begin
    len_clamp = dma_len;
    if (dma_len == 4'd0) begin
      len_clamp = 4'd1;
    end else if (dma_len > BMAX) begin
      len_clamp = BMAX;
    end
  end

  // Grant cycle is the first beat, so it uses the clamped length directly.
  always_comb begin
    own_cpu  = 1'b0;
    own_dma  = 1'b0;
    done     = 1'b0;
    cnt_d    = 4'd0;
    state_d  = IDLE;
    beat_cnt = len_clamp;
    if (rst_n) begin
      if (state_q == DMA && dma_req) begin
        own_dma  = 1'b1;
        beat_cnt = cnt_q;
      end else if (dma_req &&
                   (!cpu_req || (forced && !done_q))) begin
        own_dma = 1'b1;
      end else if (cpu_req) begin
        own_cpu = 1'b1;
      end
      if (own_dma) begin
        done    = (beat_cnt == 4'd1);
        cnt_d   = beat_cnt - 4'd1;
        state_d = done ? IDLE : DMA;
      end else if (own_cpu) begin
        state_d = CPU;
      end
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  logic [7:0] starve_q;

  assign forced = (starve_q >= 8'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= 8'd0;
    end else if (!dma_req || own_dma) begin
      starve_q <= 8'd0;
    end else if (starve_q != 8'hFF) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      done_q     <= 1'b0;
      rd_cpu_q   <= 1'b0;
      rd_dma_q   <= 1'b0;
      cpu_hold_q <= 16'd0;
      dma_hold_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done;
      rd_cpu_q <= own_cpu & ~cpu_wen;
      rd_dma_q <= own_dma & ~dma_wen;
      if (rd_cpu_q) cpu_hold_q <= mem_rdata;
      if (rd_dma_q) dma_hold_q <= mem_rdata;
    end
  end

  always_comb begin
    mem_addr  = 16'd0;
    mem_wdata = 16'd0;
    mem_wen   = 1'b0;
    unique case (1'b1)
      own_cpu: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wen   = cpu_wen;
      end
      own_dma: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_wen   = dma_wen;
      end
      default: ;
    endcase
  end

  // Registered read state is masked while reset is held low.
  assign cpu_stall = cpu_req & ~own_cpu & rst_n;
  assign dma_gnt   = own_dma;
  assign dma_done  = done;
  assign cpu_rvld  = rd_cpu_q & rst_n;
  assign dma_rvld  = rd_dma_q & rst_n;
  assign cpu_rdata = !rst_n ? 16'd0 :
                     (rd_cpu_q ? mem_rdata : cpu_hold_q);
  assign dma_rdata = !rst_n ? 16'd0 :
                     (rd_dma_q ? mem_rdata : dma_hold_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver queues hand-computed
// per-cycle expectations, negedge monitor pops and compares.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wen;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvld;
  logic [15:0] cpu_rdata;
  logic        dma_req, dma_wen;
  logic [15:0] dma_addr, dma_wdata;
  logic [3:0]  dma_len;
  logic        dma_gnt, dma_done, dma_rvld;
  logic [15:0] dma_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;

  typedef struct {
    int          id;
    bit          stall, gnt, done, wen;
    logic [15:0] maddr;
    bit          crv;
    logic [15:0] crd;
    bit          drv;
    logic [15:0] drd;
    bit          chk;
  } exp_t;

  exp_t sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_step = 0;
  logic [15:0] ram [65536];

  always #5 clk = ~clk;

  dmem_arbiter #(.BURST_MAX(8), .STARVE_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
    .cpu_stall(cpu_stall), .cpu_rvld(cpu_rvld),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wen(dma_wen),
    .dma_len(dma_len), .dma_gnt(dma_gnt),
    .dma_done(dma_done), .dma_rvld(dma_rvld),
    .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'hA000 + 16'(i);
    ram[16'h0010] = 16'hBEEF;
    mem_rdata = 16'd0;
  end

  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      bit ok;
      e = sbq.pop_front();
      ok = (cpu_stall == e.stall) && (dma_gnt == e.gnt) &&
           (dma_done == e.done) && (mem_addr == e.maddr) &&
           (mem_wen == e.wen) &&
           (cpu_rvld == e.crv) && (dma_rvld == e.drv);
      if ((e.crv || e.chk) && cpu_rdata != e.crd) ok = 1'b0;
      if ((e.drv || e.chk) && dma_rdata != e.drd) ok = 1'b0;
      n_run++;
      if (!ok) begin
        n_fail++;
        $display("FAIL step%0d: got stall=%0b gnt=%0b done=%0b addr=%h wen=%0b crv=%0b crd=%h drv=%0b drd=%h; want stall=%0b gnt=%0b done=%0b addr=%h wen=%0b crv=%0b crd=%h drv=%0b drd=%h",
                 e.id, cpu_stall, dma_gnt, dma_done, mem_addr, mem_wen,
                 cpu_rvld, cpu_rdata, dma_rvld, dma_rdata,
                 e.stall, e.gnt, e.done, e.maddr, e.wen,
                 e.crv, e.crd, e.drv, e.drd);
      end
    end
  end

  task automatic step(
    input bit rst, input bit creq, input logic [15:0] ca,
    input bit cw, input bit dreq, input logic [15:0] da,
    input bit dw, input logic [3:0] dl,
    input bit es, input bit eg, input bit ed,
    input logic [15:0] ema,
    input bit ecrv, input logic [15:0] ecrd,
    input bit edrv, input logic [15:0] edrd, input bit chk);
    exp_t e;
    rst_n     = rst;
    cpu_req   = creq;
    cpu_addr  = ca;
    cpu_wen   = cw;
    cpu_wdata = 16'hC000 + ca;
    dma_req   = dreq;
    dma_addr  = da;
    dma_wen   = dw;
    dma_wdata = 16'hD000 + da;
    dma_len   = dl;
    e.id    = n_step;
    e.stall = es;
    e.gnt   = eg;
    e.done  = ed;
    e.wen   = eg ? dw : ((creq && !es && rst) ? cw : 1'b0);
    e.maddr = ema;
    e.crv   = ecrv;
    e.crd   = ecrd;
    e.drv   = edrv;
    e.drd   = edrd;
    e.chk   = chk;
    sbq.push_back(e);
    n_step++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit dm, dn, pc, prev_dm;
    int p, wait_cyc;
    rst_n = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wen = 1'b0;
    dma_addr = '0; dma_wdata = '0; dma_wen = 1'b0; dma_len = '0;
    @(posedge clk);
    #1;
    // reset: requests present, all outputs forced to 0
    step(0,1,16'h0001,0, 1,16'h0002,0,4'd3, 0,0,0,16'h0, 0,16'h0,0,16'h0,1);
    step(0,1,16'h0001,0, 1,16'h0002,0,4'd3, 0,0,0,16'h0, 0,16'h0,0,16'h0,1);
    // 3-beat DMA read burst from idle
    step(1,0,16'h0,0, 1,16'h0020,0,4'd3, 0,1,0,16'h0020, 0,16'h0,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h0021,0,4'd3, 0,1,0,16'h0021, 0,16'h0,1,16'hA020,0);
    step(1,0,16'h0,0, 1,16'h0022,0,4'd3, 0,1,1,16'h0022, 0,16'h0,1,16'hA021,0);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 0,16'h0,1,16'hA022,0);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 0,16'h0,0,16'hA022,1);
    // len 0 -> single write beat; CPU wins the cycle after done
    step(1,0,16'h0,0, 1,16'h0030,1,4'd0, 0,1,1,16'h0030, 0,16'h0,0,16'h0,0);
    step(1,1,16'h0040,0, 1,16'h0031,0,4'd0, 0,0,0,16'h0040, 0,16'h0,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h0031,0,4'd0, 0,1,1,16'h0031, 1,16'hA040,0,16'h0,0);
    step(1,1,16'h0030,0, 0,16'h0,0,4'd0, 0,0,0,16'h0030, 0,16'h0,1,16'hA031,0);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 1,16'hD030,0,16'h0,0);
    // len 12 clamps to 8 beats
    for (int k = 0; k < 8; k++) begin
      step(1,0,16'h0,0, 1,16'h0050 + 16'(k),0,4'd12,
           0,1,(k == 7),16'h0050 + 16'(k),
           0,16'h0,(k > 0),16'hA04F + 16'(k),0);
    end
    step(1,1,16'h0060,0, 1,16'h0058,0,4'd1, 0,0,0,16'h0060, 0,16'h0,1,16'hA057,0);
    step(1,0,16'h0,0, 1,16'h0058,0,4'd1, 0,1,1,16'h0058, 1,16'hA060,0,16'h0,0);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 0,16'h0,1,16'hA058,0);
    // len 4 aborted after 2 beats; CPU served that cycle
    step(1,0,16'h0,0, 1,16'h0070,0,4'd4, 0,1,0,16'h0070, 0,16'h0,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h0071,0,4'd4, 0,1,0,16'h0071, 0,16'h0,1,16'hA070,0);
    step(1,1,16'h0080,0, 0,16'h0,0,4'd4, 0,0,0,16'h0080, 0,16'h0,1,16'hA071,0);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 1,16'hA080,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h0090,0,4'd2, 0,1,0,16'h0090, 0,16'h0,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h0091,0,4'd2, 0,1,1,16'h0091, 0,16'h0,1,16'hA090,0);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 0,16'h0,1,16'hA091,0);
    // 40 contested cycles: CPU always wins unless starve guard enabled
    prev_dm = 1'b0;
    for (int k = 0; k < 40; k++) begin
      p  = k % 18;
      dm = 1'b0;
      dn = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      dm = (p >= 16);
      dn = (p == 17);
`endif
      pc = (k > 0) && !prev_dm;
      step(1,1,16'h00A0,0, 1,16'h00B0,0,4'd2,
           dm,dm,dn,(dm ? 16'h00B0 : 16'h00A0),
           pc,16'hA0A0,prev_dm,16'hA0B0,0);
      prev_dm = dm;
    end
    // CPU read, then reset in the middle of a DMA burst
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 1,16'hA0A0,0,16'h0,0);
    step(1,1,16'h0010,0, 0,16'h0,0,4'd0, 0,0,0,16'h0010, 0,16'h0,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h00C0,0,4'd4, 0,1,0,16'h00C0, 1,16'hBEEF,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h00C1,0,4'd4, 0,1,0,16'h00C1, 0,16'h0,1,16'hA0C0,0);
    step(0,1,16'h0012,0, 1,16'h00C2,0,4'd4, 0,0,0,16'h0, 0,16'h0,0,16'h0,1);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 0,16'h0,0,16'h0,1);
    step(1,0,16'h0,0, 1,16'h00C2,0,4'd4, 0,1,0,16'h00C2, 0,16'h0,0,16'h0,0);
    step(1,0,16'h0,0, 1,16'h00C3,0,4'd4, 0,1,0,16'h00C3, 0,16'h0,1,16'hA0C2,0);
    step(1,0,16'h0,0, 1,16'h00C4,0,4'd4, 0,1,0,16'h00C4, 0,16'h0,1,16'hA0C3,0);
    step(1,0,16'h0,0, 1,16'h00C5,0,4'd4, 0,1,1,16'h00C5, 0,16'h0,1,16'hA0C4,0);
    step(1,0,16'h0,0, 0,16'h0,0,4'd0, 0,0,0,16'h0, 0,16'h0,1,16'hA0C5,0);
    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sbq.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: BURST_MAX, 8, maximum DMA beats per grant (legal range 1..15).
REQ-002 SHALL have parameter: STARVE_LIMIT, 16, consecutive denied DMA cycles before forced DMA grant (legal range 1..255).
REQ-003 SHALL have ports:
clk  in  1  single clock; all state changes on its rising edge
rst_n  in  1  reset, synchronous, active-low
cpu_req  in  1  CPU requests data port 1 this cycle
cpu_addr  in  16  CPU address
cpu_wdata  in  16  CPU write data
cpu_wen  in  1  CPU write enable
cpu_stall  out  1  CPU request not served this cycle
cpu_rvld  out  1  cpu_rdata valid
cpu_rdata  out  16  read data returned to CPU
dma_req  in  1  DMA requests/holds port
dma_addr  in  16  DMA address
dma_wdata  in  16  DMA write data
dma_wen  in  1  DMA write enable
dma_len  in  4  burst length, sampled at grant
dma_gnt  out  1  DMA owns port this cycle
dma_done  out  1  final beat of completed burst
dma_rvld  out  1  dma_rdata valid
dma_rdata  out  16  read data returned to DMA
mem_addr  out  16  to data RAM port 1
mem_wdata  out  16  to data RAM port 1
mem_wen  out  1  to data RAM port 1
mem_rdata  in  16  data RAM port 1 read data, 1-cycle latency

Function
REQ-004 SHALL implement FSM states IDLE, CPU, DMA; owner of current cycle: CPU in CPU, DMA in DMA, none in IDLE.
REQ-005 State for the next cycle from IDLE/CPU: DMA if dma_req and (not cpu_req or forced grant); else CPU if cpu_req; else IDLE.
REQ-006 Decision of REQ-005 SHALL be combinational in the request cycle: the winning requester is served in the same cycle (zero grant latency) and the FSM register records the owner.
REQ-007 On DMA grant, beat counter SHALL load dma_len clamped to 1..BURST_MAX (0 -> 1, >BURST_MAX -> BURST_MAX).
REQ-008 In DMA, each cycle with dma_req=1 SHALL be one beat; counter decrements; beat with counter=1 SHALL assert dma_done and return to IDLE/CPU per REQ-005 inputs next cycle.
REQ-009 dma_req=0 while in DMA SHALL abort burst: no beat, no dma_done, dma_gnt=0, transition per REQ-005 in that same cycle.
REQ-010 New DMA burst SHALL NOT start in the cycle following dma_done if cpu_req=1 (CPU gets at least one cycle between bursts).
REQ-011 cpu_stall = cpu_req and owner is not CPU.
REQ-012 mem_addr/mem_wdata SHALL mux the owner's inputs; mem_wen = owner's wen when owner valid; no owner -> mem_addr=0, mem_wdata=0, mem_wen=0.
REQ-013 Registered rd_owner SHALL record owner and !wen each cycle; next cycle cpu_rvld or dma_rvld pulses for reads only, x_rdata = mem_rdata; x_rdata holds last value otherwise.
REQ-014 CPU wins simultaneous requests except under REQ-016.

Reset
REQ-015 rst_n=0 at clk edge SHALL force IDLE, beat counter 0, starve counter 0, rd_owner none, cpu_rdata=dma_rdata=0; during reset all outputs 0; reset mid-burst aborts without dma_done and without rvld for in-flight read.

Configuration
REQ-016 Macro DMEM_ARB_STARVE_EN defined: starve counter increments each cycle dma_req=1 and DMA denied, clears on DMA grant or dma_req=0; at STARVE_LIMIT next contested cycle grants DMA (forced grant, cpu_stall=1).
REQ-017 Macro undefined: no starve counter logic; CPU strictly wins; DMA may starve indefinitely.

Verification
REQ-018 dma_req=1, dma_len=3, cpu_req=0 from IDLE -> dma_gnt 3 cycles, dma_done on 3rd, mem_addr follows dma_addr, then IDLE.
REQ-019 cpu_req and dma_req both 1, macro undefined, 40 cycles -> cpu_stall=0, dma_gnt=0 throughout.
REQ-020 Same stimulus, DMEM_ARB_STARVE_EN, STARVE_LIMIT=16 -> DMA granted on cycle 17, cpu_stall=1 during burst, CPU served cycle after dma_done.
REQ-021 dma_len=0 -> 1-beat burst; dma_len=12, BURST_MAX=8 -> 8 beats, dma_done on 8th.
REQ-022 DMA burst len 4, dma_req dropped after beat 2 -> no dma_done, dma_gnt=0 that cycle, CPU served if requesting.
REQ-023 CPU read addr 0x0010 (RAM holds 0xBEEF) then rst_n=0 mid DMA burst -> cpu_rvld with 0xBEEF next cycle; after reset all outputs 0, state IDLE, no dma_done.
